reg_file_sb: RTL

Parametrised register file for the single-cycle/pipelined RISC-V datapath, replacing the fixed 32x32 two-read-port file. It adds a configurable number of read ports, hardwired-zero x0, optional write-to-read bypass, an asynchronous clear, and a per-register busy scoreboard. The decode stage uses the scoreboard to detect RAW hazards on in-flight results. Sits between decode (read and issue side) and writeback (write side).

---
 rtl/reg_file_sb.sv | 82 ++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file with hardwired-zero x0, optional write-to-read bypass,
// and a per-register busy scoreboard used by decode for RAW hazard detection.
module reg_file_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRP*AW-1:0]    rd_addr,
    output logic [NRP*XLEN-1:0]  rd_data,
    output logic [NRP-1:0]       rd_busy,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [XLEN-1:0]      wd,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    output logic [AW:0]          busy_cnt,
    output logic                 all_idle
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;
    logic             wr_v;
    logic             iss_v;
    logic             cnt_set;
    logic             cnt_clr;

    assign wr_v  = we && (wa != '0);
    assign iss_v = iss_valid && (iss_addr != '0);

    // Write and issue update; issue is applied last so it wins a same-address collision.
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        cnt_set = 1'b0;
        cnt_clr = 1'b0;
        if (wr_v) begin
            regs_d[wa] = wd;
            busy_d[wa] = 1'b0;
            cnt_clr    = busy_q[wa] && !(iss_v && (iss_addr == wa));
        end
        if (iss_v) begin
            busy_d[iss_addr] = 1'b1;
            cnt_set          = !busy_q[iss_addr];
        end
        busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_set) - (AW+1)'(cnt_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign all_idle = (busy_cnt_q == '0);

    // Read ports: x0 reads zero; a same-cycle write to the port's address forwards wd
    // and also masks the busy bit, since the value is already available.
    for (genvar g = 0; g < int'(NRP); g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        assign ra  = rd_addr[g*AW +: AW];
        assign hit = (BYPASS != 0) && we && (wa == ra);
        assign rd_data[g*XLEN +: XLEN] = (ra == '0) ? '0 : (hit ? wd : regs_q[ra]);
        assign rd_busy[g] = busy_q[ra] && (ra != '0) && !hit;
    end

endmodule
